// File: rtl/irrigation_pkg.sv
// Shared types and code maps for the irrigation controller and its status decoder.
// Status codes here must stay in step with the 7-segment decoder's code map.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIP,
    ST_SPRINK,
    ST_REFILL,
    ST_FAULT
  } state_e;

  localparam logic [3:0] C_IDLE   = 4'b0000;
  localparam logic [3:0] C_DRIP   = 4'b0001;
  localparam logic [3:0] C_SPRINK = 4'b0010;
  localparam logic [3:0] C_REFILL = 4'b0011;
  localparam logic [3:0] C_FAULT  = 4'b0100;

  localparam logic [1:0] SOIL_WET   = 2'b00;
  localparam logic [1:0] SOIL_MOIST = 2'b01;
  localparam logic [1:0] SOIL_DRY   = 2'b10;
  localparam logic [1:0] SOIL_FAULT = 2'b11;

  // A broken moisture probe or contradictory float switches both mean the sensors cannot be trusted.
  function automatic logic sensors_bad(input logic [1:0] soil_f, input logic low_f, input logic full_f);
    return (soil_f == SOIL_FAULT) || (low_f && full_f);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus stability filter: the output follows the synchronized
// input only after it has held one value for DEBOUNCE_CYCLES cycles (2 + DEBOUNCE_CYCLES total).
module sensor_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] filt_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q == filt_q) begin
      cnt_d = '0;
    end else begin
      // A different candidate value restarts the stability run at its first cycle.
      if (sync_q != cand_q) begin
        cand_d = sync_q;
        cnt_d  = CW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CNT_DONE) begin
        filt_d = sync_q;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      cand_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      cand_q <= cand_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/irrigation_ctrl.sv
// Irrigation controller: debounced sensors drive a Moore FSM that owns the drip valve,
// sprinkler valve, refill pump, alarm and status code; outputs move one cycle after the filtered inputs.
module irrigation_ctrl
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int MAX_IRRIG_CYCLES  = 1000,
  parameter int MAX_REFILL_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] soil,
  input  logic       tank_low,
  input  logic       tank_full,
  input  logic       fault_clr,
  output logic       valve_drip,
  output logic       valve_sprink,
  output logic       pump_fill,
  output logic       alarm,
  output logic [3:0] C
);

  localparam int            MAX_CYC     = (MAX_IRRIG_CYCLES > MAX_REFILL_CYCLES) ?
                                          MAX_IRRIG_CYCLES : MAX_REFILL_CYCLES;
  localparam int            TW          = $clog2(MAX_CYC);
  localparam logic [TW-1:0] IRRIG_LAST  = TW'(MAX_IRRIG_CYCLES - 1);
  localparam logic [TW-1:0] REFILL_LAST = TW'(MAX_REFILL_CYCLES - 1);
  localparam logic [TW-1:0] TMR_SAT     = {TW{1'b1}};

  logic       en_f;
  logic [1:0] soil_f;
  logic       low_f;
  logic       full_f;

  sensor_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enable (
    .clk(clk), .rst(rst), .raw_i(enable), .filt_o(en_f)
  );
  sensor_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_soil (
    .clk(clk), .rst(rst), .raw_i(soil), .filt_o(soil_f)
  );
  sensor_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_low (
    .clk(clk), .rst(rst), .raw_i(tank_low), .filt_o(low_f)
  );
  sensor_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_full (
    .clk(clk), .rst(rst), .raw_i(tank_full), .filt_o(full_f)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          drip_q, drip_d;
  logic          sprink_q, sprink_d;
  logic          pump_q, pump_d;
  logic          alarm_q, alarm_d;
  logic [3:0]    code_q, code_d;
  logic          bad;
  logic          timeout;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    drip_d   = 1'b0;
    sprink_d = 1'b0;
    pump_d   = 1'b0;
    alarm_d  = 1'b0;
    code_d   = C_IDLE;
    bad      = sensors_bad(soil_f, low_f, full_f);
    timeout  = (((state_q == ST_DRIP) || (state_q == ST_SPRINK)) && (timer_q == IRRIG_LAST)) ||
               ((state_q == ST_REFILL) && (timer_q == REFILL_LAST));

    if (state_q == ST_FAULT) begin
      if (fault_clr && !bad) state_d = ST_IDLE;
    end else if (bad || timeout) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en_f) begin
            if (low_f)                     state_d = ST_REFILL;
            else if (soil_f == SOIL_DRY)   state_d = ST_SPRINK;
            else if (soil_f == SOIL_MOIST) state_d = ST_DRIP;
          end
        end
        ST_DRIP: begin
          if (!en_f || (soil_f == SOIL_WET)) state_d = ST_IDLE;
          else if (low_f)                    state_d = ST_REFILL;
          else if (soil_f == SOIL_DRY)       state_d = ST_SPRINK;
        end
        // Moist soil keeps sprinkling; there is deliberately no step back down to drip.
        ST_SPRINK: begin
          if (!en_f || (soil_f == SOIL_WET)) state_d = ST_IDLE;
          else if (low_f)                    state_d = ST_REFILL;
        end
        // A refill always runs to the full switch, regardless of enable.
        ST_REFILL: begin
          if (full_f) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (((state_q == ST_DRIP) || (state_q == ST_SPRINK) || (state_q == ST_REFILL)) &&
                 (timer_q != TMR_SAT)) begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_d)
      ST_DRIP:   begin drip_d   = 1'b1; code_d = C_DRIP;   end
      ST_SPRINK: begin sprink_d = 1'b1; code_d = C_SPRINK; end
      ST_REFILL: begin pump_d   = 1'b1; code_d = C_REFILL; end
      ST_FAULT:  begin alarm_d  = 1'b1; code_d = C_FAULT;  end
      default:   code_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      drip_q   <= 1'b0;
      sprink_q <= 1'b0;
      pump_q   <= 1'b0;
      alarm_q  <= 1'b0;
      code_q   <= C_IDLE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      drip_q   <= drip_d;
      sprink_q <= sprink_d;
      pump_q   <= pump_d;
      alarm_q  <= alarm_d;
      code_q   <= code_d;
    end
  end

  assign valve_drip   = drip_q;
  assign valve_sprink = sprink_q;
  assign pump_fill    = pump_q;
  assign alarm        = alarm_q;
  assign C            = code_q;

endmodule
